mult_result_acc: RTL and testbench
==================================

Name: mult_result_acc

Overview:
- Downstream consumer of booth_mult.
- Captures each signed product M when booth_mult signals done, and sums N_ACC consecutive products into a signed accumulator.
- Presents each finished sum on a valid/ready output handshake.
- Sits between the sequential multiplier and the result sink, so the pair forms a sequential MAC.

Parameters:
- D_IN, 8, operand width of the upstream multiplier; the product width is 2*D_IN.
- N_ACC, 4, number of products per accumulated sum; must be 2 or more.
- ACC_W, 18, accumulator and sum width in bits, signed; must be at least 2*D_IN.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- done  input  1  booth_mult done; level signal that can stay high for several cycles.
- M  input  2*D_IN  signed product from booth_mult; valid whenever done is high.
- clr  input  1  synchronous clear; discards any partial sum and returns to ACCUM.
- sum  output  ACC_W  signed accumulated sum; valid while sum_valid is high.
- sum_valid  output  1  sum is available.
- sum_ready  input  1  sink accepts sum; transfer occurs when sum_valid and sum_ready are both high on a clk edge.
- cnt  output  clog2(N_ACC)+1  number of products in the current partial sum.
- overrun  output  1  sticky flag: a product was dropped while in HOLD.

Behaviour:
- Reset, asynchronous on rst_n low:
  - sum=0, sum_valid=0, cnt=0, overrun=0.
  - acc=0, done_q=0, state=ACCUM.
- Product event:
  - Defined as a rising edge of done: done=1 and done_q=0, where done_q is done registered on clk.
  - A level that stays high generates exactly one event.
  - M is sampled in the same cycle as the event.
- Sign extension: M is sign-extended from 2*D_IN bits to ACC_W bits before the add.
- Arithmetic: acc is two's complement and wraps modulo 2^ACC_W by default (see Optional Feature).
- State ACCUM, on each event:
  - If cnt < N_ACC-1: acc <= acc + ext(M), cnt <= cnt+1.
  - If cnt == N_ACC-1: sum <= acc + ext(M), sum_valid <= 1, acc <= 0, cnt <= 0, state <= HOLD.
  - Latency: sum_valid rises on the clk edge that registers the final event, one cycle after done rises.
- State HOLD:
  - sum and sum_valid stay stable until the handshake completes.
  - On handshake: sum_valid <= 0, state <= ACCUM.
- Simultaneous handshake and event in HOLD:
  - The handshake completes.
  - The product becomes the first term of the next group: acc <= ext(M), cnt <= 1.
- Event in HOLD without handshake: the product is dropped, overrun <= 1, acc and cnt are unchanged.
- overrun is cleared only by rst_n or clr.
- clr has priority over every other action:
  - acc=0, cnt=0, sum_valid=0, overrun=0, state=ACCUM.
  - An event in the same cycle as clr is discarded.
  - done_q still updates.
- rst_n asserted mid-group loses the partial sum. After release, the first rising edge of done is counted as an event; a done already high at release counts once.
- sum holds its last value after the handshake; it is not cleared.

Optional Feature:
- Macro: MULT_ACC_SAT_EN.
- When defined:
  - Every add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Overflow is detected as both operand signs equal and the result sign different.
  - The clamp is toward the operands' sign.
  - Saturation is sticky within a group, since later adds start from the clamped value.
- When undefined: plain wrap-around, no extra logic.

Decomposition:
- Shared package mult_pkg:
  - State enum {ACCUM, HOLD}.
  - Constant function clog2.
  - Constants for the default widths: D_IN=8, PROD_W=2*D_IN.
- Sub-module sat_add, parameterised on W:
  - Combinational signed adder with an optional saturation stage controlled by MULT_ACC_SAT_EN.
  - Instantiated once for the accumulate path.
- Edge detect and FSM live in the top module.

Test Plan:
1. Default params, sum_ready=1, feed booth_mult with the pairs (1,0), (-128,127), (-128,-128), (127,127). Required response: products 0, -16256, 16384, 16129; one sum_valid pulse with sum=16257; cnt sequence 1,2,3,0.
2. Hold done high for 5 cycles with M=100, then pulse it 3 more times with M=100. Required response: exactly 4 events, sum=400, no double counting.
3. sum_ready=0 after a completed group, then apply 2 more events. Required response: sum stays 16257 and sum_valid stays 1; overrun=1; cnt=0. Then raise sum_ready together with an event of M=5. Required response: handshake completes, cnt=1, next sum includes the 5.
4. Apply clr after 2 events of 16384, then 4 events of M=1. Required response: sum=4, overrun=0.
5. N_ACC=2, ACC_W=16, two events of 16384. Required response: with MULT_ACC_SAT_EN sum=32767; without it sum=-32768.
6. Assert rst_n low mid-group after 3 events, then release. Required response: outputs return to reset values; the next 4 events of M=-1 give sum=-4.

Source files
------------

// File: rtl/mult_result_acc_pkg.sv
// mult_pkg: shared state encoding, width defaults and clog2 for the result accumulator.
package mult_pkg;
    typedef enum logic {ACCUM, HOLD} state_t;
    localparam int D_IN_DEF = 8;
    localparam int PROD_W_DEF = 2 * D_IN_DEF;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin end
        return r;
    endfunction
endpackage

// File: rtl/mult_result_acc_if.sv
// mult_result_acc_if: product input and sum valid/ready handshake.
interface mult_result_acc_if #(parameter int D_IN = 8, parameter int ACC_W = 18) ();
    logic done;
    logic signed [2*D_IN-1:0] M;
    logic signed [ACC_W-1:0] sum;
    logic sum_valid;
    logic sum_ready;
    modport master (input done, M, sum_ready, output sum, sum_valid);
    modport slave (output done, M, sum_ready, input sum, sum_valid);
endinterface

// File: rtl/mult_result_acc_sat_add.sv
// sat_add: signed adder; MULT_ACC_SAT_EN clamps overflow toward the operands' sign.
module sat_add #(parameter int W = 18) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);
    logic signed [W-1:0] s;
    assign s = a + b;
`ifdef MULT_ACC_SAT_EN
    logic ovf;
    always_comb begin
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        y = ovf ? (a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : s;
    end
`else
    assign y = s;
`endif
endmodule

// File: rtl/mult_result_acc.sv
// mult_result_acc: sums N_ACC booth_mult products and offers each sum on valid/ready.
// Build with MULT_ACC_SAT_EN for saturating instead of wrapping accumulation.
module mult_result_acc
    import mult_pkg::*;
#(
    parameter int D_IN = D_IN_DEF,
    parameter int N_ACC = 4,
    parameter int ACC_W = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    mult_result_acc_if.master bus,
    output logic [clog2(N_ACC):0] cnt,
    output logic overrun
);
    localparam int CW = clog2(N_ACC) + 1;
    localparam logic [CW-1:0] LAST = CW'(N_ACC - 1);
    state_t state, state_nxt;
    logic done_q, ev, hs, fin, take, drop;
    logic signed [2*D_IN-1:0] m;
    logic signed [ACC_W-1:0] acc, ext_m, add_out;
    assign m = bus.M;
    assign ext_m = ACC_W'(m);
    sat_add #(.W(ACC_W)) u_add (.a(acc), .b(ext_m), .y(add_out));
    always_comb begin
        ev = bus.done & ~done_q;
        hs = bus.sum_valid & bus.sum_ready;
        fin = (state == ACCUM) && (cnt == LAST);
        // in HOLD acc is already zero, so a product arriving with the handshake starts the next group
        take = ev && (state == ACCUM || hs);
        drop = ev && (state == HOLD) && !hs;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = clr ? ACCUM
                  : (state == ACCUM) ? ((ev && fin) ? HOLD : ACCUM)
                  : (hs ? ACCUM : HOLD);
    end
    always_comb begin
        bus.sum_valid = (state == HOLD);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            acc <= '0;
            cnt <= '0;
            overrun <= 1'b0;
            bus.sum <= '0;
        end else begin
            done_q <= bus.done;
            if (clr) begin
                acc <= '0;
                cnt <= '0;
                overrun <= 1'b0;
            end else begin
                if (take) begin
                    acc <= fin ? '0 : add_out;
                    cnt <= fin ? '0 : cnt + 1'b1;
                end
                if (take && fin) bus.sum <= add_out;
                if (drop) overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mult_result_acc.sv
// tb_mult_result_acc: directed vectors for the product accumulator, default and N_ACC=2/ACC_W=16 builds.
module tb_mult_result_acc;
    logic clk = 1'b0;
    logic rst_n, clr0, clr1, ov0, ov1;
    logic [2:0] cnt0;
    logic [1:0] cnt1;
    int total = 0;
    int bad = 0;
    mult_result_acc_if #(.D_IN(8), .ACC_W(18)) b0 ();
    mult_result_acc_if #(.D_IN(8), .ACC_W(16)) b1 ();
    mult_result_acc #(.D_IN(8), .N_ACC(4), .ACC_W(18)) d0 (
        .clk(clk), .rst_n(rst_n), .clr(clr0), .bus(b0.master), .cnt(cnt0), .overrun(ov0)
    );
    mult_result_acc #(.D_IN(8), .N_ACC(2), .ACC_W(16)) d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .bus(b1.master), .cnt(cnt1), .overrun(ov1)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic pulse(input int v);
        @(negedge clk);
        b0.done = 1'b1;
        b0.M = 16'(v);
        @(negedge clk);
        b0.done = 1'b0;
    endtask
    task automatic pulse1(input int v);
        @(negedge clk);
        b1.done = 1'b1;
        b1.M = 16'(v);
        @(negedge clk);
        b1.done = 1'b0;
    endtask
    int pa[4] = '{1, -128, -128, 127};
    int pb[4] = '{0, 127, -128, 127};
    int cexp[4] = '{1, 2, 3, 0};
    initial begin
        rst_n = 1'b0;
        clr0 = 1'b0;
        clr1 = 1'b0;
        b0.done = 1'b0;
        b0.M = '0;
        b0.sum_ready = 1'b1;
        b1.done = 1'b0;
        b1.M = '0;
        b1.sum_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_sum", b0.sum, 0);
        check("rst_valid", b0.sum_valid, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_overrun", ov0, 0);
        rst_n = 1'b1;
        // group of four booth products, sink always ready
        for (int i = 0; i < 4; i++) begin
            pulse(pa[i] * pb[i]);
            check("t1_cnt", cnt0, cexp[i]);
        end
        check("t1_valid", b0.sum_valid, 1);
        check("t1_sum", b0.sum, 16257);
        @(negedge clk);
        check("t1_valid_drop", b0.sum_valid, 0);
        // level held high counts once
        @(negedge clk);
        b0.done = 1'b1;
        b0.M = 16'sd100;
        repeat (5) @(negedge clk);
        b0.done = 1'b0;
        check("t2_cnt_level", cnt0, 1);
        for (int i = 0; i < 3; i++) pulse(100);
        check("t2_valid", b0.sum_valid, 1);
        check("t2_sum", b0.sum, 400);
        @(negedge clk);
        // sink stalls, extra products are dropped
        b0.sum_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(pa[i] * pb[i]);
        pulse(7);
        pulse(7);
        check("t3_sum_hold", b0.sum, 16257);
        check("t3_valid_hold", b0.sum_valid, 1);
        check("t3_overrun", ov0, 1);
        check("t3_cnt", cnt0, 0);
        @(negedge clk);
        b0.sum_ready = 1'b1;
        b0.done = 1'b1;
        b0.M = 16'sd5;
        @(negedge clk);
        b0.done = 1'b0;
        check("t3_hs_cnt", cnt0, 1);
        check("t3_hs_valid", b0.sum_valid, 0);
        for (int i = 0; i < 3; i++) pulse(1);
        check("t3_next_sum", b0.sum, 8);
        check("t3_overrun_sticky", ov0, 1);
        @(negedge clk);
        // clear mid-group, with a coincident event discarded
        pulse(16384);
        pulse(16384);
        check("t4_cnt_pre", cnt0, 2);
        @(negedge clk);
        clr0 = 1'b1;
        b0.done = 1'b1;
        b0.M = 16'sd999;
        @(negedge clk);
        clr0 = 1'b0;
        b0.done = 1'b0;
        check("t4_clr_cnt", cnt0, 0);
        check("t4_clr_overrun", ov0, 0);
        for (int i = 0; i < 4; i++) pulse(1);
        check("t4_sum", b0.sum, 4);
        check("t4_overrun", ov0, 0);
        @(negedge clk);
        // narrow build: overflow wraps or saturates
        pulse1(16384);
        check("t5_cnt", cnt1, 1);
        pulse1(16384);
        check("t5_valid", b1.sum_valid, 1);
`ifdef MULT_ACC_SAT_EN
        check("t5_pos_edge", b1.sum, 32767);
`else
        check("t5_pos_edge", b1.sum, -32768);
`endif
        @(negedge clk);
        pulse1(-16384);
        pulse1(-16385);
`ifdef MULT_ACC_SAT_EN
        check("t5_neg_edge", b1.sum, -32768);
`else
        check("t5_neg_edge", b1.sum, 32767);
`endif
        @(negedge clk);
        // reset mid-group, done already high at release
        for (int i = 0; i < 3; i++) pulse(10);
        check("t6_cnt_pre", cnt0, 3);
        @(negedge clk);
        rst_n = 1'b0;
        b0.done = 1'b1;
        b0.M = -16'sd1;
        #1;
        check("t6_rst_cnt", cnt0, 0);
        check("t6_rst_sum", b0.sum, 0);
        check("t6_rst_valid", b0.sum_valid, 0);
        check("t6_rst_overrun", ov0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        b0.done = 1'b0;
        check("t6_first_event", cnt0, 1);
        for (int i = 0; i < 3; i++) pulse(-1);
        check("t6_valid", b0.sum_valid, 1);
        check("t6_sum", b0.sum, -4);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
